rnn_host_responder: RTL and testbench



---
 rtl/rnn_host_responder_if.sv | 22 ++
 rtl/rnn_host_responder.sv | 185 ++++++++++++++++++
 tb/tb_rnn_host_responder.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rnn_host_responder_if.sv
// Engine-side memory/stream bus between the RNN engine and its host responder.
interface rnn_host_responder_if;
  logic        busy;
  logic        i_en;
  logic        mce;
  logic [16:0] maddr;
  logic [2:0]  msel;
  logic [19:0] mdata_w;
  logic        ready;
  logic [31:0] idata;
  logic [19:0] mdata_r;

  modport master (
    output busy, i_en, mce, maddr, msel, mdata_w,
    input  ready, idata, mdata_r
  );

  modport slave (
    input  busy, i_en, mce, maddr, msel, mdata_w,
    output ready, idata, mdata_r
  );
endinterface

// File: rtl/rnn_host_responder.sv
// Host-side responder for the RNN engine: launches runs, feeds input vectors,
// serves weight-store reads and collects hidden-state writes into an output stream.
module rnn_host_responder #(
  parameter int unsigned IN_DEPTH  = 4,
  parameter int unsigned OUT_DEPTH = 8,
  parameter int unsigned WX_BASE   = 0,
  parameter int unsigned BX_BASE   = 2048,
  parameter int unsigned WH_BASE   = 4096,
  parameter int unsigned BH_BASE   = 8192
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [19:0] cfg_tcount,
  input  logic        x_valid,
  output logic        x_ready,
  input  logic [31:0] x_data,
  output logic        h_valid,
  input  logic        h_ready,
  output logic [19:0] h_data,
  output logic [10:0] h_tidx,
  output logic [5:0]  h_hidx,
  output logic        done,
  output logic        err_ovf,
  output logic        err_unf,
  output logic [13:0] ext_addr,
  input  logic [19:0] ext_rdata,
  rnn_host_responder_if.slave eng
);

  localparam int unsigned IN_AW  = $clog2(IN_DEPTH);
  localparam int unsigned OUT_AW = $clog2(OUT_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

  typedef struct packed {
    logic [19:0] data;
    logic [10:0] tidx;
    logic [5:0]  hidx;
  } h_word_t;

  state_t      state;
  logic [19:0] tcount_q;
  logic [20:0] budget_q;
  logic        ready_q;
  logic        done_q;
  logic [31:0] idata_q;
  logic        err_ovf_q;
  logic        err_unf_q;

  logic [31:0]     in_mem [IN_DEPTH];
  logic [IN_AW-1:0] in_rd, in_wr;
  logic [IN_AW:0]   in_cnt;

  h_word_t          out_mem [OUT_DEPTH];
  logic [OUT_AW-1:0] out_rd, out_wr;
  logic [OUT_AW:0]   out_cnt;

  logic        in_empty, in_full, x_push, pop_req, pop_cycle, in_pop;
  logic        out_empty, out_full, wr_req, out_push, out_pop;
  logic [19:0] mdata_r_c;

  assign in_empty  = (in_cnt == '0);
  assign in_full   = (in_cnt == (IN_AW+1)'(IN_DEPTH));
  assign x_push    = x_valid && !in_full;
  assign pop_req   = ((state == S_ARM) || (state == S_RUN)) && eng.i_en;
  assign pop_cycle = pop_req && (budget_q != '0);
  assign in_pop    = pop_cycle && !in_empty;

  assign out_empty = (out_cnt == '0);
  assign out_full  = (out_cnt == (OUT_AW+1)'(OUT_DEPTH));
  assign wr_req    = eng.mce && (eng.msel == 3'b101);
  // a pop in the same cycle does not make room for a push into a full FIFO
  assign out_push  = wr_req && !out_full;
  assign out_pop   = !out_empty && h_ready;

  // Zero-latency read decode into the flat weight store
  always_comb begin
    ext_addr  = '0;
    mdata_r_c = '0;
    case (eng.msel)
      3'b000:  ext_addr = 14'(WX_BASE) + 14'(eng.maddr[10:0]);
      3'b001:  ext_addr = 14'(BX_BASE) + 14'(eng.maddr[5:0]);
      3'b010:  ext_addr = 14'(WH_BASE) + 14'(eng.maddr[11:0]);
      3'b011:  ext_addr = 14'(BH_BASE) + 14'(eng.maddr[5:0]);
      3'b100:  mdata_r_c = tcount_q;
      default: ;
    endcase
    if (!eng.msel[2]) mdata_r_c = ext_rdata;
  end

  // Run control, pop budget and sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      tcount_q  <= '0;
      budget_q  <= '0;
      idata_q   <= '0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: if (start && !in_empty) begin
          state    <= S_ARM;
          ready_q  <= 1'b1;
          tcount_q <= cfg_tcount;
          budget_q <= 21'(cfg_tcount) + 21'd1;
        end
        S_ARM: if (eng.busy) begin
          state   <= S_RUN;
          ready_q <= 1'b0;
        end
        S_RUN: if (!eng.busy) begin
          state  <= S_DONE;
          done_q <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
      if (pop_cycle) budget_q <= budget_q - 21'd1;
      // an empty FIFO or an exhausted budget both present zero to the engine
      if (pop_req) idata_q <= in_pop ? in_mem[in_rd] : '0;
      if (pop_cycle && in_empty) err_unf_q <= 1'b1;
      if (wr_req && out_full) err_ovf_q <= 1'b1;
    end
  end

  // Input vector FIFO storage
  always_ff @(posedge clk) begin
    if (x_push) in_mem[in_wr] <= x_data;
  end

  // Input vector FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      in_rd  <= '0;
      in_wr  <= '0;
      in_cnt <= '0;
    end else begin
      if (x_push) in_wr <= in_wr + IN_AW'(1);
      if (in_pop) in_rd <= in_rd + IN_AW'(1);
      case ({x_push, in_pop})
        2'b10:   in_cnt <= in_cnt + (IN_AW+1)'(1);
        2'b01:   in_cnt <= in_cnt - (IN_AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Hidden-state output FIFO; storage is cleared so the head reads zero after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      out_rd  <= '0;
      out_wr  <= '0;
      out_cnt <= '0;
      for (int i = 0; i < int'(OUT_DEPTH); i++) out_mem[i] <= '0;
    end else begin
      if (out_push) begin
        out_mem[out_wr] <= '{data: eng.mdata_w, tidx: eng.maddr[16:6], hidx: eng.maddr[5:0]};
        out_wr          <= out_wr + OUT_AW'(1);
      end
      if (out_pop) out_rd <= out_rd + OUT_AW'(1);
      case ({out_push, out_pop})
        2'b10:   out_cnt <= out_cnt + (OUT_AW+1)'(1);
        2'b01:   out_cnt <= out_cnt - (OUT_AW+1)'(1);
        default: ;
      endcase
    end
  end

  assign x_ready     = !in_full;
  assign h_valid     = !out_empty;
  assign h_data      = out_mem[out_rd].data;
  assign h_tidx      = out_mem[out_rd].tidx;
  assign h_hidx      = out_mem[out_rd].hidx;
  assign done        = done_q;
  assign err_ovf     = err_ovf_q;
  assign err_unf     = err_unf_q;
  assign eng.ready   = ready_q;
  assign eng.idata   = idata_q;
  assign eng.mdata_r = mdata_r_c;

endmodule

// File: tb/tb_rnn_host_responder.sv
// Directed + randomized bench for rnn_host_responder against a queue-based model.
module tb_rnn_host_responder;
  localparam int unsigned IN_DEPTH  = 4;
  localparam int unsigned OUT_DEPTH = 8;
  localparam int unsigned WX_BASE   = 0;
  localparam int unsigned BX_BASE   = 2048;
  localparam int unsigned WH_BASE   = 4096;
  localparam int unsigned BH_BASE   = 8192;

  logic        clk = 1'b0;
  logic        reset, start, x_valid, x_ready, h_valid, h_ready, done, err_ovf, err_unf;
  logic [19:0] cfg_tcount, h_data, ext_rdata;
  logic [31:0] x_data;
  logic [10:0] h_tidx;
  logic [5:0]  h_hidx;
  logic [13:0] ext_addr;
  logic [19:0] store [16384];

  always #5 clk = ~clk;

  rnn_host_responder_if bus();
  assign ext_rdata = store[ext_addr];

  rnn_host_responder #(
    .IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH), .WX_BASE(WX_BASE),
    .BX_BASE(BX_BASE), .WH_BASE(WH_BASE), .BH_BASE(BH_BASE)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_tcount(cfg_tcount),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .h_valid(h_valid), .h_ready(h_ready), .h_data(h_data), .h_tidx(h_tidx), .h_hidx(h_hidx),
    .done(done), .err_ovf(err_ovf), .err_unf(err_unf),
    .ext_addr(ext_addr), .ext_rdata(ext_rdata), .eng(bus)
  );

  // Reference model: queues for both FIFOs, run phase 0 idle / 1 armed / 2 running / 3 done
  logic [31:0] in_q [$];
  logic [36:0] out_q [$];
  int          phase, budget, emitted, total, bad;
  logic [19:0] m_t;
  logic [31:0] m_idata;
  bit          m_unf, m_ovf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    in_q.delete(); out_q.delete();
    phase = 0; budget = 0; m_t = '0; m_idata = '0; m_unf = 0; m_ovf = 0;
  endtask

  function automatic logic [13:0] exp_addr();
    case (bus.msel)
      3'd0:    return 14'(WX_BASE + int'(bus.maddr[10:0]));
      3'd1:    return 14'(BX_BASE + int'(bus.maddr[5:0]));
      3'd2:    return 14'(WH_BASE + int'(bus.maddr[11:0]));
      3'd3:    return 14'(BH_BASE + int'(bus.maddr[5:0]));
      default: return 14'd0;
    endcase
  endfunction

  function automatic logic [19:0] exp_mdata();
    if (bus.msel < 3'd4) return store[exp_addr()];
    if (bus.msel == 3'd4) return m_t;
    return 20'd0;
  endfunction

  // One clock: check combinational/stream outputs, advance the model, check registered outputs
  task automatic tick();
    bit acc, x_acc, wr, full;
    #1;
    chk("ext_addr", 64'(ext_addr), 64'(exp_addr()));
    chk("mdata_r", 64'(bus.mdata_r), 64'(exp_mdata()));
    chk("x_ready", 64'(x_ready), 64'(in_q.size() < IN_DEPTH));
    chk("h_valid", 64'(h_valid), 64'(out_q.size() != 0));
    if (h_valid === 1'b1 && h_ready) begin
      emitted++;
      if (out_q.size() == 0) chk("h_spurious", 64'(h_valid), 64'(0));
      else chk("h_word", 64'({h_data, h_tidx, h_hidx}), 64'(out_q[0]));
    end
    if (reset) model_clear();
    else begin
      acc   = (phase == 0) && start && (in_q.size() != 0);
      x_acc = x_valid && (in_q.size() < IN_DEPTH);
      full  = (out_q.size() == OUT_DEPTH);
      wr    = bus.mce && (bus.msel == 3'b101);
      if (out_q.size() != 0 && h_ready) void'(out_q.pop_front());
      if (wr) begin
        if (full) m_ovf = 1;
        else out_q.push_back({bus.mdata_w, bus.maddr});
      end
      if ((phase == 1 || phase == 2) && bus.i_en) begin
        if (budget > 0) begin
          budget--;
          if (in_q.size() > 0) m_idata = in_q.pop_front();
          else begin m_idata = '0; m_unf = 1; end
        end else m_idata = '0;
      end
      if (x_acc) in_q.push_back(x_data);
      case (phase)
        0: if (acc) begin phase = 1; m_t = cfg_tcount; budget = int'(cfg_tcount) + 1; end
        1: if (bus.busy) phase = 2;
        2: if (!bus.busy) phase = 3;
        default: phase = 0;
      endcase
    end
    @(posedge clk); #1;
    chk("ready", 64'(bus.ready), 64'(phase == 1));
    chk("done", 64'(done), 64'(phase == 3));
    chk("idata", 64'(bus.idata), 64'(m_idata));
    chk("err_unf", 64'(err_unf), 64'(m_unf));
    chk("err_ovf", 64'(err_ovf), 64'(m_ovf));
  endtask

  task automatic push_vec(input logic [31:0] v);
    x_data = v; x_valid = 1'b1; tick(); x_valid = 1'b0;
  endtask

  task automatic launch(input logic [19:0] t);
    cfg_tcount = t; start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pop(input string tag, input logic [31:0] exp);
    bus.i_en = 1'b1; tick(); bus.i_en = 1'b0;
    chk(tag, 64'(bus.idata), 64'(exp));
  endtask

  initial begin
    int e0;
    logic [31:0] cv [3];
    logic [31:0] rv;
    reset = 1'b1; start = 1'b0; cfg_tcount = '0; x_valid = 1'b0; x_data = '0; h_ready = 1'b0;
    bus.busy = 1'b0; bus.i_en = 1'b0; bus.mce = 1'b0; bus.maddr = '0; bus.msel = '0; bus.mdata_w = '0;
    total = 0; bad = 0; emitted = 0;
    for (int i = 0; i < 16384; i++) store[i] = 20'($urandom);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.ready), 64'(0));
    chk("rst_idata", 64'(bus.idata), 64'(0));
    chk("rst_x_ready", 64'(x_ready), 64'(1));
    chk("rst_h_valid", 64'(h_valid), 64'(0));
    chk("rst_h_word", 64'({h_data, h_tidx, h_hidx}), 64'(0));
    chk("rst_flags", 64'({done, err_ovf, err_unf}), 64'(0));
    chk("rst_ext_addr", 64'(ext_addr), 64'(0));
    chk("rst_mdata_r", 64'(bus.mdata_r), 64'(store[0]));
    reset = 1'b0;
    tick();

    // start with nothing queued is ignored
    launch(20'd3);
    chk("empty_start", 64'(bus.ready), 64'(0));
    tick();

    // T=0: one vector, one pop, 64 outputs for step 0
    push_vec(32'h0000_0001);
    launch(20'd0);
    chk("A_ready", 64'(bus.ready), 64'(1));
    tick();
    chk("A_ready_hold", 64'(bus.ready), 64'(1));
    bus.busy = 1'b1; tick();
    chk("A_ready_fall", 64'(bus.ready), 64'(0));
    pop("A_pop", 32'h0000_0001);
    pop("A_trail", 32'h0);
    h_ready = 1'b1; e0 = emitted;
    for (int i = 0; i < 64; i++) begin
      bus.mce = 1'b1; bus.msel = 3'b101; bus.maddr = {11'd0, 6'(i)}; bus.mdata_w = 20'($urandom);
      tick();
    end
    bus.mce = 1'b0; bus.msel = 3'b000; bus.busy = 1'b0;
    tick();
    chk("A_done", 64'(done), 64'(1));
    tick();
    chk("A_done_pulse", 64'(done), 64'(0));
    repeat (3) tick();
    chk("A_emitted", 64'(emitted - e0), 64'(64));
    chk("A_no_err", 64'({err_ovf, err_unf}), 64'(0));

    // T=2: three vectors in order, trailing request gives zero without error
    cv[0] = 32'hA5A5_0000; cv[1] = 32'h0000_FFFF; cv[2] = 32'h1234_5678;
    for (int i = 0; i < 3; i++) push_vec(cv[i]);
    launch(20'd2);
    bus.busy = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      pop("C_pop", cv[i]);
      tick();
      chk("C_hold", 64'(bus.idata), 64'(cv[i]));
    end
    pop("C_trail", 32'h0);
    chk("C_no_unf", 64'(err_unf), 64'(0));
    bus.busy = 1'b0; tick(); tick();

    // T=1 with one vector: second pop underflows
    rv = $urandom;
    push_vec(rv);
    launch(20'd1);
    bus.busy = 1'b1; tick();
    pop("D_pop", rv);
    pop("D_unf_data", 32'h0);
    chk("D_unf", 64'(err_unf), 64'(1));
    bus.busy = 1'b0; tick(); tick();

    // nine writes with the stream stalled: eighth fills, ninth overflows
    h_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bus.mce = 1'b1; bus.msel = 3'b101; bus.maddr = 17'($urandom); bus.mdata_w = 20'($urandom);
      tick();
      if (i == 7) chk("E_no_ovf_yet", 64'(err_ovf), 64'(0));
    end
    bus.mce = 1'b0; bus.msel = 3'b000;
    chk("E_ovf", 64'(err_ovf), 64'(1));
    h_ready = 1'b1; e0 = emitted;
    repeat (12) tick();
    chk("E_emitted", 64'(emitted - e0), 64'(8));
    chk("E_drained", 64'(h_valid), 64'(0));

    // decode corner values and a randomized run with T=5
    bus.msel = 3'b010; bus.maddr = 17'h00FFF; #1;
    chk("dec_wh_top", 64'(ext_addr), 64'(14'h1FFF));
    for (int i = 0; i < 4; i++) push_vec($urandom);
    launch(20'd5);
    bus.msel = 3'b100; #1;
    chk("dec_tcount", 64'(bus.mdata_r), 64'(5));
    bus.msel = 3'b110; #1;
    chk("dec_zero", 64'(bus.mdata_r), 64'(0));
    bus.busy = 1'b1;
    for (int i = 0; i < 120; i++) begin
      bus.i_en = 1'($urandom_range(0, 1));
      bus.mce = 1'($urandom_range(0, 1));
      bus.msel = 3'($urandom_range(0, 7));
      bus.maddr = 17'($urandom);
      bus.mdata_w = 20'($urandom);
      h_ready = 1'($urandom_range(0, 1));
      x_valid = 1'($urandom_range(0, 1));
      x_data = $urandom;
      tick();
    end
    bus.i_en = 1'b0; bus.mce = 1'b0; bus.msel = 3'b000; x_valid = 1'b0; bus.busy = 1'b0;
    tick();
    chk("R_done", 64'(done), 64'(1));
    h_ready = 1'b1;
    repeat (10) tick();

    // reset in the middle of a run, then a clean run
    push_vec(32'hCAFE_0001);
    launch(20'd3);
    bus.busy = 1'b1; tick();
    bus.i_en = 1'b1; tick(); bus.i_en = 1'b0;
    h_ready = 1'b0; bus.mce = 1'b1; bus.msel = 3'b101;
    tick(); tick();
    bus.mce = 1'b0; bus.msel = 3'b000;
    chk("F_pre_valid", 64'(h_valid), 64'(1));
    reset = 1'b1; tick(); reset = 1'b0; bus.busy = 1'b0;
    chk("F_ready", 64'(bus.ready), 64'(0));
    chk("F_h_valid", 64'(h_valid), 64'(0));
    chk("F_x_ready", 64'(x_ready), 64'(1));
    chk("F_flags", 64'({err_ovf, err_unf, done}), 64'(0));
    tick();
    rv = $urandom;
    push_vec(rv);
    launch(20'd0);
    chk("F_restart", 64'(bus.ready), 64'(1));
    bus.busy = 1'b1; tick();
    pop("F_pop", rv);
    bus.busy = 1'b0; tick();
    chk("F_done", 64'(done), 64'(1));
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
